// File: rtl/router_fsm.sv
// Packet router control FSM: sequences header decode, payload load, FIFO-full stalls and parity check.
// Optional build macro ROUTER_FSM_DROP_INVALID_EN adds a DROP_PKT state that discards packets addressed to 3.
module router_fsm #(
    parameter int PKT_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pkt_valid,
    input  logic [1:0]           data_in,
    input  logic                 fifo_full,
    input  logic                 fifo_empty_0,
    input  logic                 fifo_empty_1,
    input  logic                 fifo_empty_2,
    input  logic                 soft_rst_0,
    input  logic                 soft_rst_1,
    input  logic                 soft_rst_2,
    input  logic                 parity_done,
    input  logic                 low_pkt_valid,
    output logic                 detect_add,
    output logic                 lfd_state,
    output logic                 ld_state,
    output logic                 laf_state,
    output logic                 full_state,
    output logic                 rst_int_reg,
    output logic                 write_enb_reg,
    output logic                 busy,
    output logic [PKT_CNT_W-1:0] pkt_cnt
);

    localparam logic [3:0] DECODE_ADDRESS     = 4'd0;
    localparam logic [3:0] LOAD_FIRST_DATA    = 4'd1;
    localparam logic [3:0] WAIT_TILL_EMPTY    = 4'd2;
    localparam logic [3:0] LOAD_DATA          = 4'd3;
    localparam logic [3:0] FIFO_FULL_STATE    = 4'd4;
    localparam logic [3:0] LOAD_AFTER_FULL    = 4'd5;
    localparam logic [3:0] LOAD_PARITY        = 4'd6;
    localparam logic [3:0] CHECK_PARITY_ERROR = 4'd7;
`ifdef ROUTER_FSM_DROP_INVALID_EN
    localparam logic [3:0] DROP_PKT           = 4'd8;
`endif

    localparam logic [PKT_CNT_W-1:0] CNT_ONE = {{(PKT_CNT_W-1){1'b0}}, 1'b1};

    logic [3:0]           state_q, state_d;
    logic [1:0]           addr_q, addr_d;
    logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;

    logic empty_hdr;
    logic empty_addr;
    logic soft_rst_sel;
    logic pkt_done;

    // Empty flag of the destination named by the incoming header byte.
    always_comb begin
        empty_hdr = 1'b0;
        case (data_in)
            2'd0:    empty_hdr = fifo_empty_0;
            2'd1:    empty_hdr = fifo_empty_1;
            2'd2:    empty_hdr = fifo_empty_2;
            default: empty_hdr = 1'b0;
        endcase
    end

    // Flags of the latched destination; address 3 has no FIFO and no soft reset.
    always_comb begin
        empty_addr   = 1'b0;
        soft_rst_sel = 1'b0;
        case (addr_q)
            2'd0: begin
                empty_addr   = fifo_empty_0;
                soft_rst_sel = soft_rst_0;
            end
            2'd1: begin
                empty_addr   = fifo_empty_1;
                soft_rst_sel = soft_rst_1;
            end
            2'd2: begin
                empty_addr   = fifo_empty_2;
                soft_rst_sel = soft_rst_2;
            end
            default: begin
                empty_addr   = 1'b0;
                soft_rst_sel = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DECODE_ADDRESS: begin
                if (pkt_valid) begin
                    if (data_in != 2'd3) begin
                        state_d = empty_hdr ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
                    end
`ifdef ROUTER_FSM_DROP_INVALID_EN
                    else begin
                        state_d = DROP_PKT;
                    end
`endif
                end
            end
            WAIT_TILL_EMPTY: begin
                if (empty_addr) state_d = LOAD_FIRST_DATA;
            end
            LOAD_FIRST_DATA: state_d = LOAD_DATA;
            LOAD_DATA: begin
                if (fifo_full)       state_d = FIFO_FULL_STATE;
                else if (!pkt_valid) state_d = LOAD_PARITY;
            end
            FIFO_FULL_STATE: begin
                if (!fifo_full) state_d = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
                if (parity_done)        state_d = DECODE_ADDRESS;
                else if (low_pkt_valid) state_d = LOAD_PARITY;
                else                    state_d = LOAD_DATA;
            end
            LOAD_PARITY: state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR: begin
                state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            end
`ifdef ROUTER_FSM_DROP_INVALID_EN
            DROP_PKT: begin
                if (!pkt_valid) state_d = DECODE_ADDRESS;
            end
`endif
            default: state_d = DECODE_ADDRESS;
        endcase
        if (soft_rst_sel) state_d = DECODE_ADDRESS;
    end

    always_comb begin
        addr_d = addr_q;
        if (state_q == DECODE_ADDRESS && pkt_valid) addr_d = data_in;
    end

    // A packet completes only on a natural return to decode; soft-reset aborts are not counted.
    assign pkt_done = !soft_rst_sel && (state_d == DECODE_ADDRESS) &&
                      ((state_q == CHECK_PARITY_ERROR) || (state_q == LOAD_AFTER_FULL));

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (pkt_done && (pkt_cnt_q != {PKT_CNT_W{1'b1}})) pkt_cnt_d = pkt_cnt_q + CNT_ONE;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= DECODE_ADDRESS;
            addr_q    <= 2'd0;
            pkt_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign detect_add    = (state_q == DECODE_ADDRESS);
    assign lfd_state     = (state_q == LOAD_FIRST_DATA);
    assign ld_state      = (state_q == LOAD_DATA);
    assign laf_state     = (state_q == LOAD_AFTER_FULL);
    assign full_state    = (state_q == FIFO_FULL_STATE);
    assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    assign write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY) ||
                           (state_q == LOAD_AFTER_FULL);
`ifdef ROUTER_FSM_DROP_INVALID_EN
    assign busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA) ||
                             (state_q == DROP_PKT));
`else
    assign busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));
`endif
    assign pkt_cnt       = pkt_cnt_q;

endmodule

// File: doc/router_fsm.md
ROUTER_FSM -- requirements
Module: router_fsm

Interface
REQ-001 SHALL have parameter PKT_CNT_W, default 8, width of completed-packet counter.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port pkt_valid  input  1  source indicates a packet byte on the bus.
REQ-005 SHALL have port data_in  input  2  destination address field of the header byte.
REQ-006 SHALL have port fifo_full  input  1  full flag of the currently selected destination FIFO.
REQ-007 SHALL have port fifo_empty_0/1/2  input  1 each  empty flags of destination FIFOs.
REQ-008 SHALL have port soft_rst_0/1/2  input  1 each  per-destination read-timeout soft reset.
REQ-009 SHALL have port parity_done  input  1  parity byte already captured by the register block.
REQ-010 SHALL have port low_pkt_valid  input  1  pkt_valid fell while the FIFO was full.
REQ-011 SHALL have ports detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg, write_enb_reg, busy  output  1 each  state decodes.
REQ-012 SHALL have port pkt_cnt  output  PKT_CNT_W  completed-packet count.

Function
REQ-013 SHALL implement states DECODE_ADDRESS, LOAD_FIRST_DATA, WAIT_TILL_EMPTY, LOAD_DATA, FIFO_FULL_STATE, LOAD_AFTER_FULL, LOAD_PARITY, CHECK_PARITY_ERROR; one transition per clk.
REQ-014 SHALL latch data_in into a 2-bit addr register in DECODE_ADDRESS when pkt_valid=1; addr is held in all other states.
REQ-015 DECODE_ADDRESS: pkt_valid=1, data_in<3, fifo_empty[data_in]=1 -> LOAD_FIRST_DATA; fifo_empty[data_in]=0 -> WAIT_TILL_EMPTY; otherwise stay.
REQ-016 WAIT_TILL_EMPTY: fifo_empty[addr]=1 -> LOAD_FIRST_DATA; else stay.
REQ-017 LOAD_FIRST_DATA -> LOAD_DATA unconditionally.
REQ-018 LOAD_DATA: fifo_full=1 -> FIFO_FULL_STATE; else pkt_valid=0 -> LOAD_PARITY; else stay; fifo_full has priority over pkt_valid.
REQ-019 FIFO_FULL_STATE: fifo_full=1 stay; else -> LOAD_AFTER_FULL.
REQ-020 LOAD_AFTER_FULL: parity_done=1 -> DECODE_ADDRESS; else low_pkt_valid=1 -> LOAD_PARITY; else -> LOAD_DATA.
REQ-021 LOAD_PARITY -> CHECK_PARITY_ERROR unconditionally.
REQ-022 CHECK_PARITY_ERROR: fifo_full=1 -> FIFO_FULL_STATE; else -> DECODE_ADDRESS.
REQ-023 soft_rst_[addr]=1 SHALL force next state DECODE_ADDRESS from any state, overriding REQ-015..022; soft resets of non-selected destinations SHALL be ignored.
REQ-024 Outputs SHALL be Moore decodes of the current state: detect_add=DECODE_ADDRESS; lfd_state=LOAD_FIRST_DATA; ld_state=LOAD_DATA; laf_state=LOAD_AFTER_FULL; full_state=FIFO_FULL_STATE; rst_int_reg=CHECK_PARITY_ERROR.
REQ-025 write_enb_reg SHALL be 1 in LOAD_DATA, LOAD_PARITY, LOAD_AFTER_FULL; else 0.
REQ-026 busy SHALL be 0 in DECODE_ADDRESS and LOAD_DATA; 1 in all other states.
REQ-027 pkt_cnt SHALL increment on each transition into DECODE_ADDRESS from CHECK_PARITY_ERROR or LOAD_AFTER_FULL; saturate at all-ones; transitions caused by soft reset SHALL NOT count.

Reset
REQ-028 rst=0 at a clk edge SHALL set state DECODE_ADDRESS, addr=0, pkt_cnt=0; rst has priority over soft reset and all transitions, including mid-packet.
REQ-029 Reset values SHALL be detect_add=1; all other 1-bit outputs 0; pkt_cnt=0.

Configuration
REQ-030 With ROUTER_FSM_DROP_INVALID_EN defined: DECODE_ADDRESS with pkt_valid=1 and data_in=3 SHALL go to added state DROP_PKT (busy=0, write_enb_reg=0, all other decodes 0), which returns to DECODE_ADDRESS one cycle after pkt_valid=0, not counted in pkt_cnt.
REQ-031 Without ROUTER_FSM_DROP_INVALID_EN: data_in=3 SHALL leave the FSM in DECODE_ADDRESS; DROP_PKT SHALL not exist.

Verification
REQ-032 Header addr=1, fifo_empty_1=1, 3 payload bytes, pkt_valid low -> DECODE,LFD,LD x3,LOAD_PARITY,CHECK_PARITY_ERROR,DECODE; pkt_cnt=1.
REQ-033 Header addr=2, fifo_empty_2=0 for 5 cycles -> WAIT_TILL_EMPTY 5 cycles, busy=1, then LOAD_FIRST_DATA.
REQ-034 fifo_full=1 for 4 cycles in LOAD_DATA -> FIFO_FULL_STATE 4 cycles, write_enb_reg=0, then LOAD_AFTER_FULL -> LOAD_DATA.
REQ-035 soft_rst_0=1 with addr=0 in LOAD_DATA -> DECODE_ADDRESS next cycle, pkt_cnt unchanged; soft_rst_1=1 there -> no effect.
REQ-036 rst=0 in FIFO_FULL_STATE -> DECODE_ADDRESS, detect_add=1, pkt_cnt=0.
REQ-037 Header data_in=3, 4-byte packet: DROP_INVALID_EN defined -> DROP_PKT until pkt_valid=0, then DECODE; undefined -> DECODE throughout.
